// File: rtl/ahb_cordic_pkg.sv
// Shared encodings for the AHB-Lite multi-channel CORDIC front end:
// register offsets, bus codes, STATUS bit positions and the bus FSM states.
package ahb_cordic_pkg;

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_FLUSH  = 2'd2;
    localparam logic [1:0] OFF_RSVD   = 2'd3;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam int unsigned ST_FULL  = 16;
    localparam int unsigned ST_EMPTY = 17;
    localparam int unsigned ST_OVF   = 18;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ERR1 = 2'd2,
        S_ERR2 = 2'd3
    } state_t;

endpackage

// File: rtl/cordic_res_fifo.sv
// Per-channel result FIFO: synchronous, power-of-two depth, with clear.
// A push into a full FIFO is accepted only if a pop frees a slot that cycle.
module cordic_res_fifo
    import ahb_cordic_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic [DW-1:0]            din,
    input  logic                     pop,
    output logic [DW-1:0]            dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = DEPTH[CW-1:0];

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          wr;
    logic          rd;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign rd    = pop && !empty;
    assign wr    = push && (!full || rd);
    assign drop  = push && !wr;
    assign dout  = mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr) wptr <= wptr + 1'b1;
            if (rd) rptr <= rptr + 1'b1;
            count <= count + CW'(wr) - CW'(rd);
        end
    end

    always_ff @(posedge clk) begin
        if (wr && !clr) mem[wptr] <= din;
    end

endmodule

// File: rtl/ahb_lite_cordic_mc.sv
// AHB-Lite slave fronting NCH CORDIC channels: issues operands, tracks
// outstanding work and queues returned results per channel.
module ahb_lite_cordic_mc
    import ahb_cordic_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int DW      = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic                HSEL,
    input  logic                HREADY,
    input  logic                HWRITE,
    input  logic [31:0]         HADDR,
    input  logic [1:0]          HTRANS,
    input  logic [2:0]          HSIZE,
    input  logic [31:0]         HWDATA,
    input  logic [2:0]          HBURST,
    input  logic                HMASTLOCK,
    input  logic [3:0]          HPROT,
    output logic                HREADYOUT,
    output logic                HRESP,
    output logic [31:0]         HRDATA,
    output logic [NCH*DW-1:0]   in_interface,
    output logic [NCH-1:0]      valid_in_interface,
    input  logic [NCH*DW-1:0]   out_interface,
    input  logic [NCH-1:0]      valid_out_interface
);

    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int CW1 = CW + 1;
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam logic [3:0]    NCH_C    = 4'(NCH);
    localparam logic [CW:0]   DEPTH_C  = DEPTH[CW:0];
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_t state, state_nx;

    logic          dp_valid, dp_write, dp_load;
    logic [2:0]    dp_ch;
    logic [1:0]    dp_off;
    logic [TW-1:0] wcnt;

    // Channel-indexed views are sized for the full 3-bit channel field.
    logic [DW-1:0] f_head   [8];
    logic [CW-1:0] f_cnt    [8];
    logic [CW-1:0] inflight [8];
    logic [7:0]    f_full, f_empty, ovf;
    logic [7:0]    ch_push, ch_iss, ch_pop, ch_flush;

    logic          accept, dp_done, issue, pop_go, flush_go;
    logic [2:0]    a_ch;
    logic [1:0]    a_off;
    logic [CW:0]   a_credit;
    logic          a_empty, a_err, a_wait;
    logic          unused_inputs;

    assign unused_inputs = ^{HBURST, HMASTLOCK, HPROT, HADDR[31:7], HADDR[1:0], HWDATA};

    assign accept   = HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
    assign a_ch     = HADDR[6:4];
    assign a_off    = HADDR[3:2];
    assign dp_done  = (state == S_IDLE) && dp_valid;
    assign issue    = dp_done && dp_write && (dp_off == OFF_DATA);
    assign pop_go   = dp_done && !dp_write && (dp_off == OFF_DATA);
    assign flush_go = dp_done && dp_write && (dp_off == OFF_FLUSH);

    for (genvar g = 0; g < 8; g++) begin : g_ch
        assign ch_iss[g]   = issue    && (dp_ch == 3'(g));
        assign ch_pop[g]   = pop_go   && (dp_ch == 3'(g));
        assign ch_flush[g] = flush_go && (dp_ch == 3'(g));

        if (g < NCH) begin : g_live
            logic          drop;
            logic [CW-1:0] infl;
            logic          ovf_q;

            cordic_res_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
                .clk   (HCLK),
                .rst_n (HRESETn),
                .clr   (ch_flush[g]),
                .push  (valid_out_interface[g]),
                .din   (out_interface[g*DW +: DW]),
                .pop   (ch_pop[g]),
                .dout  (f_head[g]),
                .count (f_cnt[g]),
                .full  (f_full[g]),
                .empty (f_empty[g]),
                .drop  (drop)
            );

            always_ff @(posedge HCLK or negedge HRESETn) begin
                if (!HRESETn) begin
                    infl  <= '0;
                    ovf_q <= 1'b0;
                end else begin
                    if (ch_iss[g] && !valid_out_interface[g])
                        infl <= infl + 1'b1;
                    else if (!ch_iss[g] && valid_out_interface[g] && infl != '0)
                        infl <= infl - 1'b1;
                    if (ch_flush[g])
                        ovf_q <= 1'b0;
                    else if (drop)
                        ovf_q <= 1'b1;
                end
            end

            assign ch_push[g]  = valid_out_interface[g];
            assign inflight[g] = infl;
            assign ovf[g]      = ovf_q;
        end else begin : g_tie
            assign f_head[g]   = '0;
            assign f_cnt[g]    = '0;
            assign f_full[g]   = 1'b0;
            assign f_empty[g]  = 1'b1;
            assign ch_push[g]  = 1'b0;
            assign inflight[g] = '0;
            assign ovf[g]      = 1'b0;
        end
    end

    // Decisions account for the pop/issue/flush/push landing on this same edge.
    always_comb begin
        a_credit = CW1'(f_cnt[a_ch]) + CW1'(inflight[a_ch]) + CW1'(ch_iss[a_ch])
                 - CW1'(ch_pop[a_ch]);
        a_empty  = ch_flush[a_ch]
                 || ((f_cnt[a_ch] == CW'(ch_pop[a_ch])) && !ch_push[a_ch]);
        a_err    = ({1'b0, a_ch} >= NCH_C)
                 || (((a_off == OFF_DATA) || (a_off == OFF_FLUSH)) && (HSIZE != HSIZE_WORD))
                 || (HWRITE && (a_off == OFF_STATUS))
                 || (HWRITE && (a_off == OFF_DATA) && (a_credit == DEPTH_C));
        a_wait   = !HWRITE && (a_off == OFF_DATA) && a_empty;
    end

    always_comb begin
        state_nx = state;
        dp_load  = 1'b0;
        case (state)
            S_IDLE, S_ERR2: begin
                state_nx = S_IDLE;
                if (accept) begin
                    if (a_err) begin
                        state_nx = S_ERR1;
                    end else begin
                        dp_load  = 1'b1;
                        state_nx = a_wait ? S_WAIT : S_IDLE;
                    end
                end
            end
            S_WAIT: begin
                if (ch_push[dp_ch])
                    state_nx = S_IDLE;
                else if (wcnt == TMO_LAST)
                    state_nx = S_ERR1;
            end
            S_ERR1:  state_nx = S_ERR2;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= S_IDLE;
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_ch    <= '0;
            dp_off   <= '0;
            wcnt     <= '0;
        end else begin
            state <= state_nx;
            wcnt  <= (state == S_WAIT) ? wcnt + 1'b1 : '0;
            if (state == S_IDLE || state == S_ERR2) begin
                dp_valid <= dp_load;
                if (dp_load) begin
                    dp_ch    <= a_ch;
                    dp_off   <= a_off;
                    dp_write <= HWRITE;
                end
            end else if (state_nx == S_ERR1) begin
                dp_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            in_interface       <= '0;
            valid_in_interface <= '0;
        end else begin
            valid_in_interface <= ch_iss[NCH-1:0];
            for (int unsigned c = 0; c < NCH; c++) begin
                if (ch_iss[c]) in_interface[c*DW +: DW] <= HWDATA[DW-1:0];
            end
        end
    end

    assign HREADYOUT = (state == S_IDLE) || (state == S_ERR2);
    assign HRESP     = (state == S_ERR1) || (state == S_ERR2);

    always_comb begin
        HRDATA = '0;
        if (dp_done && !dp_write) begin
            case (dp_off)
                OFF_DATA:   HRDATA[DW-1:0] = f_head[dp_ch];
                OFF_STATUS: begin
                    HRDATA[7:0]      = 8'(f_cnt[dp_ch]);
                    HRDATA[15:8]     = 8'(inflight[dp_ch]);
                    HRDATA[ST_FULL]  = f_full[dp_ch];
                    HRDATA[ST_EMPTY] = f_empty[dp_ch];
                    HRDATA[ST_OVF]   = ovf[dp_ch];
                end
                default:    HRDATA = '0;
            endcase
        end
    end

endmodule

// File: doc/ahb_lite_cordic_mc.md
AHB_LITE_CORDIC_MC -- requirements
Module: ahb_lite_cordic_mc

Interface
REQ-001 Parameter NCH, default 2, SHALL set the number of CORDIC channels (1..8).
REQ-002 Parameter DW, default 32, SHALL set the CORDIC word width (8..32); writes truncate to DW, reads zero-extend to 32.
REQ-003 Parameter DEPTH, default 4, SHALL set the result-FIFO entries per channel (power of 2, >=2).
REQ-004 Parameter TIMEOUT, default 255, SHALL set the maximum wait states for a read of an empty FIFO.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-006 HCLK  in  1  clock; HRESETn  in  1  async active-low reset.
REQ-007 HSEL, HREADY, HWRITE  in  1  AHB-Lite select, ready-in and direction.
REQ-008 HADDR  in  32  address; HTRANS  in  2  transfer type; HSIZE  in  3  size; HWDATA  in  32  write data.
REQ-009 HBURST  in  3, HMASTLOCK  in  1, HPROT  in  4  SHALL be ignored.
REQ-010 HREADYOUT  out  1; HRESP  out  1; HRDATA  out  32  AHB-Lite response and read data.
REQ-011 in_interface  out  NCH*DW, and valid_in_interface  out  NCH, carry the operand and a one-cycle valid per channel.
REQ-012 out_interface  in  NCH*DW, and valid_out_interface  in  NCH, carry the result and a one-cycle valid per channel.

Function
REQ-013 Address phase SHALL be accepted when HSEL && HREADY && HTRANS[1], capturing channel HADDR[6:4], offset HADDR[3:2], HWRITE and HSIZE.
REQ-014 Offsets: 0 DATA (write = issue operand, read = pop result); 1 STATUS (read only); 2 FLUSH (write clears channel FIFO and overflow bit); 3 reserved (read 0, write ignored, OKAY).
REQ-015 Channel index >= NCH, HSIZE != 3'b010 on DATA/FLUSH, or a STATUS write SHALL give an ERROR response.
REQ-016 ERROR response SHALL be two cycles: HRESP=1/HREADYOUT=0, then HRESP=1/HREADYOUT=1.
REQ-017 A DATA write SHALL complete with zero wait states, load the channel's in_interface slice on the cycle after the data phase, and pulse its valid_in_interface bit on that cycle; the slice holds until the next write.
REQ-018 Per-channel credit = FIFO count + inflight; a DATA write with credit == DEPTH SHALL give ERROR and issue nothing.
REQ-019 inflight SHALL increment on issue and decrement on valid_out; a simultaneous issue and return SHALL leave it unchanged.
REQ-020 valid_out SHALL push out_interface slice into the channel FIFO; a push when full SHALL be dropped and set sticky STATUS[18].
REQ-021 A DATA read with a non-empty FIFO SHALL complete in zero wait states with the head word and pop it.
REQ-022 A DATA read with an empty FIFO SHALL hold HREADYOUT=0 until a push arrives, then complete on the next cycle with that word; after TIMEOUT wait cycles with no push it SHALL give ERROR.
REQ-023 A simultaneous push and pop SHALL leave the FIFO count unchanged.
REQ-024 STATUS SHALL read {13'b0, overflow, empty, full, inflight[7:0], count[7:0]}.
REQ-025 FSM SHALL have states S_IDLE, S_WAIT, S_ERR1, S_ERR2.
REQ-026 FSM transitions: S_IDLE->S_WAIT on an empty-FIFO read; S_IDLE->S_ERR1 on an error condition; S_WAIT->S_IDLE on push; S_WAIT->S_ERR1 on timeout; S_ERR1->S_ERR2; S_ERR2->S_IDLE (or a new decision if a transfer is pipelined).
REQ-027 HREADYOUT SHALL be 1 in S_IDLE and S_ERR2 and 0 otherwise; HRDATA SHALL be 0 outside read data phases.
REQ-028 FLUSH SHALL not modify inflight; later returns SHALL be queued normally.

Reset
REQ-029 HRESETn low SHALL asynchronously force S_IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, in_interface=0, valid_in_interface=0, all FIFOs empty, inflight=0 and overflow=0.
REQ-030 Reset during S_WAIT or an error response SHALL abandon the transfer with no further bus response.

Structure
REQ-031 Package ahb_cordic_pkg SHALL hold the offset codes, FSM state encodings, STATUS bit positions and HTRANS codes.
REQ-032 Sub-module cordic_res_fifo (DW, DEPTH) SHALL implement one synchronous FIFO with count, full and empty, instantiated NCH times by generate.

Verification
REQ-033 Write 0x1234 to ch0 DATA -> valid_in_interface[0] pulses once, in_interface[31:0]=0x1234; return 0xABCD -> read ch0 DATA gives 0xABCD with zero waits.
REQ-034 Read empty ch1 DATA, return arrives after 5 cycles -> 5 wait states, then data; no return (TIMEOUT=255) -> 255 waits then a two-cycle ERROR.
REQ-035 Issue 4 writes to ch0 (DEPTH=4) with no returns -> 5th write gives ERROR; STATUS shows inflight=4, count=0.
REQ-036 Access channel 3 with NCH=2, or a byte write to DATA -> ERROR, no valid_in pulse.
REQ-037 Same-cycle pop and push on ch0 with count=2 -> count stays 2; assert HRESETn in S_WAIT -> HREADYOUT=1 and all counts 0 immediately.
